cmd_slot_sequencer: RTL

// - Sits between the PS command stream (128-bit AXIS CMD) and the DDR4 command scheduler.
// - Each accepted 128-bit beat holds four 32-bit instruction slots; slot 0 is bits [31:0].
// - Slots are unpacked in order and presented one at a time on a valid/ready issue port.
// - Each slot's wait field inserts idle cycles before the next slot is presented.

---
 rtl/sddt_cmd_pkg.sv | 36 +++
 rtl/cmd_slot_sequencer_if.sv | 31 +++
 rtl/cmd_slot_decode.sv | 32 +++
 rtl/cmd_slot_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sddt_cmd_pkg.sv
// Shared definitions for the command slot sequencer: opcodes, slot field layout, FSM encoding.
package sddt_cmd_pkg;

  localparam int SLOTS_PER_BEAT = 4;
  localparam int SLOT_W         = 32;
  localparam int BEAT_W         = SLOTS_PER_BEAT * SLOT_W;

  localparam int OP_LSB   = 28;
  localparam int OP_W     = 4;
  localparam int BG_LSB   = 26;
  localparam int BA_LSB   = 24;
  localparam int ADDR_LSB = 7;
  localparam int WAIT_LSB = 0;

  localparam logic [OP_W-1:0] OP_NOP  = 4'd0;
  localparam logic [OP_W-1:0] OP_ACT  = 4'd1;
  localparam logic [OP_W-1:0] OP_RD   = 4'd2;
  localparam logic [OP_W-1:0] OP_WR   = 4'd3;
  localparam logic [OP_W-1:0] OP_PRE  = 4'd4;
  localparam logic [OP_W-1:0] OP_PREA = 4'd5;
  localparam logic [OP_W-1:0] OP_REF  = 4'd6;
  localparam logic [OP_W-1:0] OP_ZQCL = 4'd7;
  localparam logic [OP_W-1:0] OP_END  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_SKIP  = 2'd2,
    ST_WAIT  = 2'd3
  } state_t;

  function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
    return (op >= 4'd8) && (op <= 4'd14);
  endfunction

endpackage

// File: rtl/cmd_slot_sequencer_if.sv
// Bundles the AXIS command input, the slot issue port and the status outputs of the sequencer.
interface cmd_slot_sequencer_if #(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int ADDR_WIDTH = 17
);
  logic [127:0]            s_axis_cmd_tdata;
  logic                    s_axis_cmd_tvalid;
  logic                    s_axis_cmd_tready;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              cmd_op;
  logic [BG_WIDTH-1:0]     cmd_bg;
  logic [BANK_WIDTH-1:0]   cmd_ba;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic                    busy;
  logic                    err;
  logic [47:0]             stats;

  // Environment side: command source and scheduler.
  modport master (
    output s_axis_cmd_tdata, s_axis_cmd_tvalid, cmd_ready,
    input  s_axis_cmd_tready, cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_addr, busy, err, stats
  );

  // Sequencer side.
  modport slave (
    input  s_axis_cmd_tdata, s_axis_cmd_tvalid, cmd_ready,
    output s_axis_cmd_tready, cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_addr, busy, err, stats
  );
endinterface

// File: rtl/cmd_slot_decode.sv
// Combinational split of one 32-bit instruction slot into its fields and class flags.
module cmd_slot_decode
  import sddt_cmd_pkg::*;
#(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int WAIT_WIDTH = 7
) (
  input  logic [SLOT_W-1:0]     slot,
  output logic [OP_W-1:0]       op,
  output logic [BG_WIDTH-1:0]   bg,
  output logic [BANK_WIDTH-1:0] ba,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [WAIT_WIDTH-1:0] wait_len,
  output logic                  is_illegal,
  output logic                  is_nop,
  output logic                  is_end
);

  assign op       = slot[OP_LSB   +: OP_W];
  assign bg       = slot[BG_LSB   +: BG_WIDTH];
  assign ba       = slot[BA_LSB   +: BANK_WIDTH];
  assign addr     = slot[ADDR_LSB +: ADDR_WIDTH];
  assign wait_len = slot[WAIT_LSB +: WAIT_WIDTH];

  assign is_illegal = op_is_illegal(op);
  // Illegal slots are silently skipped like NOPs once err has been flagged.
  assign is_nop     = (op == OP_NOP) || is_illegal;
  assign is_end     = (op == OP_END);

endmodule

// File: rtl/cmd_slot_sequencer.sv
// Unpacks 128-bit command beats into four slots issued one by one with per-slot idle gaps.
// Optional macro CMD_STATS_EN enables saturating ACT/RD/WR handshake counters on stats.
module cmd_slot_sequencer
  import sddt_cmd_pkg::*;
#(
  parameter int BG_WIDTH   = 2,
  parameter int BANK_WIDTH = 2,
  parameter int ADDR_WIDTH = 17,
  parameter int WAIT_WIDTH = 7
) (
  input logic               c0_ddr4_clk,
  input logic               c0_ddr4_rst,
  cmd_slot_sequencer_if.slave bus
);

  state_t                  state;
  logic [BEAT_W-1:0]       beat_q;
  logic [1:0]              slot_idx;
  logic [WAIT_WIDTH-1:0]   wait_cnt;
  logic [WAIT_WIDTH-1:0]   cur_wait;
  logic                    valid_q;
  logic [OP_W-1:0]         op_q;
  logic [BG_WIDTH-1:0]     bg_q;
  logic [BANK_WIDTH-1:0]   ba_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    err_q;

  logic                    tready;
  logic                    accept;
  logic                    advance;
  logic                    do_decode;
  logic                    last_slot;
  logic                    hs;
  logic [1:0]              dec_idx;
  logic [SLOT_W-1:0]       dec_slot;

  logic [OP_W-1:0]         d_op;
  logic [BG_WIDTH-1:0]     d_bg;
  logic [BANK_WIDTH-1:0]   d_ba;
  logic [ADDR_WIDTH-1:0]   d_addr;
  logic [WAIT_WIDTH-1:0]   d_wait;
  logic                    d_illegal;
  logic                    d_nop;
  logic                    d_end;

  assign tready    = (state == ST_IDLE) && !c0_ddr4_rst;
  assign accept    = bus.s_axis_cmd_tvalid && tready;
  assign hs        = valid_q && bus.cmd_ready;
  assign last_slot = (slot_idx == 2'(SLOTS_PER_BEAT - 1));

  assign advance = ((state == ST_ISSUE) && bus.cmd_ready && (cur_wait == '0)) ||
                   (state == ST_SKIP) ||
                   ((state == ST_WAIT) && (wait_cnt == WAIT_WIDTH'(1)));

  assign do_decode = accept || (advance && !last_slot);

  // Slot 0 is decoded straight off the bus so it can issue the cycle after accept.
  always_comb begin
    dec_idx  = (state == ST_IDLE) ? 2'd0 : slot_idx + 2'd1;
    dec_slot = (state == ST_IDLE) ? bus.s_axis_cmd_tdata[SLOT_W-1:0]
                                  : beat_q[{dec_idx, 5'd0} +: SLOT_W];
  end

  cmd_slot_decode #(
    .BG_WIDTH   (BG_WIDTH),
    .BANK_WIDTH (BANK_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .WAIT_WIDTH (WAIT_WIDTH)
  ) u_decode (
    .slot       (dec_slot),
    .op         (d_op),
    .bg         (d_bg),
    .ba         (d_ba),
    .addr       (d_addr),
    .wait_len   (d_wait),
    .is_illegal (d_illegal),
    .is_nop     (d_nop),
    .is_end     (d_end)
  );

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      state    <= ST_IDLE;
      beat_q   <= '0;
      slot_idx <= '0;
      wait_cnt <= '0;
      cur_wait <= '0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      bg_q     <= '0;
      ba_q     <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else if (do_decode) begin
      slot_idx <= dec_idx;
      if (accept) begin
        beat_q <= bus.s_axis_cmd_tdata;
      end
      if (d_illegal) begin
        err_q <= 1'b1;
      end
      if (d_end) begin
        state   <= ST_IDLE;
        valid_q <= 1'b0;
      end else if (d_nop) begin
        valid_q <= 1'b0;
        // A NOP's gap starts on its own decode cycle, so a zero wait still costs one SKIP cycle.
        if (d_wait == '0) begin
          state <= ST_SKIP;
        end else begin
          state    <= ST_WAIT;
          wait_cnt <= d_wait;
        end
      end else begin
        state    <= ST_ISSUE;
        valid_q  <= 1'b1;
        op_q     <= d_op;
        bg_q     <= d_bg;
        ba_q     <= d_ba;
        addr_q   <= d_addr;
        cur_wait <= d_wait;
      end
    end else begin
      case (state)
        ST_ISSUE: begin
          if (bus.cmd_ready) begin
            valid_q <= 1'b0;
            if (cur_wait == '0) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_WAIT;
              wait_cnt <= cur_wait;
            end
          end
        end
        ST_SKIP: state <= ST_IDLE;
        ST_WAIT: begin
          if (wait_cnt == WAIT_WIDTH'(1)) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CMD_STATS_EN
  logic [15:0] act_cnt;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      act_cnt <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
    end else if (hs) begin
      if ((op_q == OP_ACT) && (act_cnt != 16'hFFFF)) act_cnt <= act_cnt + 16'd1;
      if ((op_q == OP_RD)  && (rd_cnt  != 16'hFFFF)) rd_cnt  <= rd_cnt  + 16'd1;
      if ((op_q == OP_WR)  && (wr_cnt  != 16'hFFFF)) wr_cnt  <= wr_cnt  + 16'd1;
    end
  end

  assign bus.stats = {wr_cnt, rd_cnt, act_cnt};
`else
  logic unused_hs;
  assign unused_hs = hs;
  assign bus.stats = 48'd0;
`endif

  assign bus.s_axis_cmd_tready = tready;
  assign bus.cmd_valid         = valid_q;
  assign bus.cmd_op            = op_q;
  assign bus.cmd_bg            = bg_q;
  assign bus.cmd_ba            = ba_q;
  assign bus.cmd_addr          = addr_q;
  assign bus.busy              = (state != ST_IDLE);
  assign bus.err               = err_q;

endmodule
